// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: state encoding, fill-side
// select values, block geometry and the block-word address helper.
package mem_arb_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int BLK_WORDS  = 8;
   localparam int WORD_IDX_W = 3;
   localparam int BASE_W     = ADDR_W - WORD_IDX_W - 1;

   localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(BLK_WORDS - 1);

   localparam logic FILL_SEL_I = 1'b0;
   localparam logic FILL_SEL_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      WR   = 2'b10,
      DONE = 2'b11
   } arb_state_e;

   // Word index is concatenated, never added, so it cannot carry into the base.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0]     base,
                                                   input logic [WORD_IDX_W-1:0] idx);
      return {base, idx, 1'b0};
   endfunction

endpackage

// File: rtl/fill_counter.sv
// Block word counter: counts enabled cycles 0..BLK_WORDS-1 and raises done once
// the last word has been counted; done holds off further counting until clear.
module fill_counter
   import mem_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   output logic [WORD_IDX_W-1:0] cnt,
   output logic                  done
);

   logic [WORD_IDX_W-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (clr) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (en && !done_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_IDX) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = done_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates single-ported main memory between I-fills, D-fills and D-side
// write-through stores; sequences 8-word fills and drives the pipeline stall.
//
// state | meaning
// IDLE  | no access in progress; grant dc_miss > dc_wr_req > ic_miss
// FILL  | issue 8 block reads back to back, write returned words into the cache
// WR    | single write-through store cycle, acked to the D-cache
// DONE  | one dead cycle so the finished requester can drop its request
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_miss,
   input  logic [ADDR_W-1:0] ic_miss_addr,
   input  logic              dc_miss,
   input  logic [ADDR_W-1:0] dc_miss_addr,
   input  logic              dc_wr_req,
   input  logic [ADDR_W-1:0] dc_wr_addr,
   input  logic [DATA_W-1:0] dc_wr_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              fill_we,
   output logic              fill_sel,
   output logic [2:0]        fill_word,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_tag_we,
   output logic              dc_wr_ack,
   output logic              cache_stall_n
);

   arb_state_e            state_q, state_d;
   logic [BASE_W-1:0]     base_q, base_d;
   logic                  sel_q, sel_d;

   logic                  cnt_clr;
   logic                  iss_en, ret_en;
   logic [WORD_IDX_W-1:0] iss_cnt, ret_cnt;
   logic                  iss_done, ret_done;
   logic                  unused_addr_bits;

   assign cnt_clr = (state_q != FILL);

   fill_counter u_iss_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (iss_en),
      .cnt  (iss_cnt),
      .done (iss_done)
   );

   fill_counter u_ret_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (ret_en),
      .cnt  (ret_cnt),
      .done (ret_done)
   );

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      sel_d       = sel_q;
      iss_en      = 1'b0;
      ret_en      = 1'b0;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_we     = 1'b0;
      fill_tag_we = 1'b0;
      dc_wr_ack   = 1'b0;

      case (state_q)
         IDLE: begin
            // The D side holds the older instruction, so it wins over the I side.
            if (dc_miss) begin
               base_d  = dc_miss_addr[ADDR_W-1:WORD_IDX_W+1];
               sel_d   = FILL_SEL_D;
               state_d = FILL;
            end else if (dc_wr_req) begin
               state_d = WR;
            end else if (ic_miss) begin
               base_d  = ic_miss_addr[ADDR_W-1:WORD_IDX_W+1];
               sel_d   = FILL_SEL_I;
               state_d = FILL;
            end
         end

         FILL: begin
            if (!iss_done) begin
               iss_en   = 1'b1;
               mem_en   = 1'b1;
               mem_addr = word_addr(base_q, iss_cnt);
            end
            if (mem_rvalid && !ret_done) begin
               ret_en  = 1'b1;
               fill_we = 1'b1;
               if (ret_cnt == LAST_IDX) begin
                  fill_tag_we = 1'b1;
                  state_d     = DONE;
               end
            end
         end

         WR: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = dc_wr_addr;
            mem_wdata = dc_wr_data;
            dc_wr_ack = 1'b1;
            state_d   = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         sel_q   <= FILL_SEL_I;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         sel_q   <= sel_d;
      end
   end

   assign fill_sel  = sel_q;
   assign fill_word = ret_cnt;
   assign fill_data = mem_rdata;

   assign cache_stall_n = ~(ic_miss | dc_miss | (dc_wr_req & ~dc_wr_ack));

   assign unused_addr_bits = ^{ic_miss_addr[WORD_IDX_W:0], dc_miss_addr[WORD_IDX_W:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed fills/stores/reset plus random
// traffic under random memory latency, checked by a separate monitor.
module tb_mem_arbiter;

   localparam int MEM_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_miss, dc_miss, dc_wr_req;
   logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
   logic        mem_en, mem_wr, mem_rvalid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        fill_we, fill_sel, fill_tag_we, dc_wr_ack, cache_stall_n;
   logic [2:0]  fill_word;
   logic [15:0] fill_data;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .ic_miss       (ic_miss),
      .ic_miss_addr  (ic_miss_addr),
      .dc_miss       (dc_miss),
      .dc_miss_addr  (dc_miss_addr),
      .dc_wr_req     (dc_wr_req),
      .dc_wr_addr    (dc_wr_addr),
      .dc_wr_data    (dc_wr_data),
      .mem_en        (mem_en),
      .mem_wr        (mem_wr),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .fill_we       (fill_we),
      .fill_sel      (fill_sel),
      .fill_word     (fill_word),
      .fill_data     (fill_data),
      .fill_tag_we   (fill_tag_we),
      .dc_wr_ack     (dc_wr_ack),
      .cache_stall_n (cache_stall_n)
   );

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          cyc;
   } iss_t;

   typedef struct {
      logic        sel;
      logic [2:0]  word;
      logic [15:0] data;
      int          cyc;
   } fil_t;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } rd_t;

   iss_t exp_iss[$];
   fil_t exp_fil[$];
   rd_t  mq[$];

   int   cyc = 0;
   logic rst_seen = 1'b1;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   int   checks = 0, failures = 0;
   int   tag_i_cnt = 0, tag_d_cnt = 0, ack_cnt = 0;
   int   seen_i = 0, seen_d = 0, seen_ack = 0;
   int   exp_tags = 0, timeouts = 0;
   logic spur, lat_rand, tb_done;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(dc_miss && dc_wr_req))
            else $error("illegal stimulus: dc_miss and dc_wr_req together");
      end
   end

   // ---------------- monitor / memory model / scoreboard ----------------
   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic summary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin : monitor
      iss_t e;
      fil_t f;
      int   lat, due, last_due, last_end;
      logic exp_stall_n;
      last_due   = 0;
      last_end   = -100;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rdata  = 16'h0;
         if (mq.size() > 0 && mq[0].due == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_fn(mq[0].addr);
            mq.delete(0);
         end else if (spur) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hDEAD;
         end
         #1;
         if (rst_seen) begin
            chk({mem_en, mem_wr, fill_we, fill_sel, fill_tag_we, dc_wr_ack, fill_word} == 9'd0
                && mem_addr == 16'd0 && mem_wdata == 16'd0, "reset_outputs",
                int'({mem_en, mem_wr, fill_we, fill_sel, fill_tag_we, dc_wr_ack, fill_word}), 0);
         end
         exp_stall_n = !(ic_miss || dc_miss || (dc_wr_req && !dc_wr_ack));
         chk(cache_stall_n == exp_stall_n, "stall_n", int'(cache_stall_n), int'(exp_stall_n));
         if (mem_en || dc_wr_ack) begin
            chk(dc_wr_ack == (mem_en && mem_wr), "wr_ack", int'(dc_wr_ack), int'(mem_en && mem_wr));
         end
         if (dc_wr_ack) ack_cnt++;

         if (mem_en) begin
            if (exp_iss.size() == 0) begin
               chk(1'b0, "unexpected_issue", int'(mem_addr), 0);
            end else begin
               e = exp_iss.pop_front();
               chk(mem_wr == e.wr && mem_addr == e.addr && (!e.wr || mem_wdata == e.wdata),
                   "issue", int'({mem_wr, mem_addr}), int'({e.wr, e.addr}));
               if (e.wr) begin
                  chk(mem_wdata == e.wdata, "store_wdata", int'(mem_wdata), int'(e.wdata));
               end
               if (e.cyc >= 0) chk(cyc == e.cyc, "issue_cycle", cyc, e.cyc);
            end
            chk(cyc >= last_end + 3, "done_gap", cyc, last_end + 3);
            if (mem_wr) begin
               last_end = cyc;
            end else begin
               lat = lat_rand ? int'($urandom_range(7, 4)) : MEM_LAT;
               due = cyc + lat;
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               mq.push_back('{mem_addr, due});
            end
         end

         if (fill_we) begin
            if (exp_fil.size() == 0) begin
               chk(1'b0, "unexpected_fill_we", int'(fill_word), 0);
            end else begin
               f = exp_fil.pop_front();
               chk(fill_sel == f.sel && fill_word == f.word && fill_data == f.data, "fill",
                   int'({fill_sel, fill_word, fill_data}), int'({f.sel, f.word, f.data}));
               if (f.cyc >= 0) chk(cyc == f.cyc, "fill_cycle", cyc, f.cyc);
               chk(fill_tag_we == (f.word == 3'd7), "tag_we", int'(fill_tag_we), int'(f.word == 3'd7));
            end
            if (fill_tag_we) begin
               last_end = cyc;
               if (fill_sel) tag_d_cnt++;
               else          tag_i_cnt++;
            end
         end else if (fill_tag_we) begin
            chk(1'b0, "tag_without_fill", 1, 0);
         end

         if (tb_done) begin
            chk(exp_iss.size() == 0, "issues_left", exp_iss.size(), 0);
            chk(exp_fil.size() == 0, "fills_left", exp_fil.size(), 0);
            chk(tag_i_cnt + tag_d_cnt == exp_tags, "tag_count", tag_i_cnt + tag_d_cnt, exp_tags);
            chk(timeouts == 0, "wait_timeout", timeouts, 0);
            summary();
            $finish;
         end
         if (cyc > 40000) begin
            chk(1'b0, "watchdog", cyc, 40000);
            summary();
            $finish;
         end
      end
   end

   // ---------------- stimulus / requester model ----------------
   task automatic tick();
      @(posedge clk);
      #2;
      if (tag_i_cnt != seen_i) begin seen_i = tag_i_cnt; ic_miss = 1'b0; end
      if (tag_d_cnt != seen_d) begin seen_d = tag_d_cnt; dc_miss = 1'b0; end
      if (ack_cnt != seen_ack) begin seen_ack = ack_cnt; dc_wr_req = 1'b0; end
   endtask

   task automatic wait_quiet(input int budget);
      int b;
      b = 0;
      while ((ic_miss || dc_miss || dc_wr_req || exp_iss.size() != 0 || exp_fil.size() != 0
              || mq.size() != 0) && b < budget) begin
         tick();
         b++;
      end
      if (b >= budget) begin
         timeouts++;
         ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
      end
      tick();
      tick();
   endtask

   // Expected block fill granted in cycle `grant`: reads base+0..base+14 on the
   // following 8 cycles, words returning MEM_LAT cycles after each read.
   function automatic void push_fill(input logic sel, input logic [15:0] addr, input int grant);
      logic [15:0] a;
      for (int i = 0; i < 8; i++) begin
         a = (addr & 16'hFFF0) + 16'(2 * i);
         exp_iss.push_back('{1'b0, a, 16'h0, grant + 1 + i});
         exp_fil.push_back('{sel, 3'(i), mem_fn(a), lat_rand ? -1 : grant + 1 + i + MEM_LAT});
      end
      exp_tags++;
   endfunction

   function automatic void push_store(input logic [15:0] addr, input logic [15:0] data, input int at);
      exp_iss.push_back('{1'b1, addr, data, at});
   endfunction

   initial begin : driver
      int g;
      logic [15:0] a, d;
      rst = 1'b1; ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
      ic_miss_addr = 16'h0; dc_miss_addr = 16'h0; dc_wr_addr = 16'h0; dc_wr_data = 16'h0;
      spur = 1'b0; lat_rand = 1'b0; tb_done = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 1: I fill of 0x1236
      g = cyc; ic_miss = 1'b1; ic_miss_addr = 16'h1236;
      push_fill(1'b0, 16'h1236, g);
      wait_quiet(200);

      // 2: simultaneous misses, D side first, I fill after DONE+IDLE
      g = cyc; ic_miss = 1'b1; ic_miss_addr = 16'h0040; dc_miss = 1'b1; dc_miss_addr = 16'h8008;
      push_fill(1'b1, 16'h8008, g);
      push_fill(1'b0, 16'h0040, g + 14);
      wait_quiet(200);

      // 3: store while idle; stray rvalid in WR/DONE; miss raised during DONE
      g = cyc; dc_wr_req = 1'b1; dc_wr_addr = 16'hA002; dc_wr_data = 16'hBEEF;
      push_store(16'hA002, 16'hBEEF, g + 1);
      tick(); spur = 1'b1;
      tick(); ic_miss = 1'b1; ic_miss_addr = 16'h0470;
      push_fill(1'b0, 16'h0470, cyc + 1);
      tick(); spur = 1'b0;
      wait_quiet(200);

      // 4: store arrives mid I-fill, granted only after DONE
      g = cyc; ic_miss = 1'b1; ic_miss_addr = 16'h2A1C;
      push_fill(1'b0, 16'h2A1C, g);
      repeat (3) tick();
      dc_wr_req = 1'b1; dc_wr_addr = 16'h3004; dc_wr_data = 16'h5A17;
      push_store(16'h3004, 16'h5A17, g + 15);
      wait_quiet(200);

      // 5: reset at the 5th issue; in-flight data and stray rvalid discarded
      g = cyc; ic_miss = 1'b1; ic_miss_addr = 16'h5552;
      for (int i = 0; i < 5; i++) begin
         exp_iss.push_back('{1'b0, 16'h5550 + 16'(2 * i), 16'h0, g + 1 + i});
      end
      exp_fil.push_back('{1'b0, 3'd0, mem_fn(16'h5550), g + 1 + MEM_LAT});
      repeat (5) tick();
      rst = 1'b1; ic_miss = 1'b0;
      tick();
      rst = 1'b0; spur = 1'b1;
      tick();
      spur = 1'b0;
      wait_quiet(200);
      g = cyc; ic_miss = 1'b1; ic_miss_addr = 16'h5552;
      push_fill(1'b0, 16'h5552, g);
      wait_quiet(200);

      // 6: random traffic with random read latency 4..7
      lat_rand = 1'b1;
      for (int k = 0; k < 24; k++) begin
         a = 16'($urandom);
         d = 16'($urandom);
         g = cyc;
         case ($urandom_range(2, 0))
            0: begin ic_miss = 1'b1; ic_miss_addr = a; push_fill(1'b0, a, g); end
            1: begin dc_miss = 1'b1; dc_miss_addr = a; push_fill(1'b1, a, g); end
            default: begin
               dc_wr_req = 1'b1; dc_wr_addr = a; dc_wr_data = d;
               push_store(a, d, g + 1);
            end
         endcase
         wait_quiet(400);
      end
      lat_rand = 1'b0;

      tb_done = 1'b1;
   end

endmodule
